mcu_responder: RTL and testbench
================================

MCU_RESPONDER -- requirements
Module: mcu_responder

Interface
REQ-001 SHALL have parameter P_DMA_LEN, default 8'hA0, number of bytes per OAM DMA transfer.
REQ-002 SHALL have parameter P_HRAM_DEPTH, default 127, number of internal HRAM bytes at FF80-FFFE.
REQ-003 iClock  in  1  clock; all state on rising edge.
REQ-004 iReset  in  1  reset iReset, synchronous, active-high; clock iClock.
REQ-005 iCpuAddr  in  16  CPU bus address.
REQ-006 iCpuData  in  8  CPU write data.
REQ-007 iCpuReadRequest  in  1  CPU read strobe.
REQ-008 iCpuWe  in  1  CPU write strobe.
REQ-009 oCpuData  out  8  registered read data to CPU.
REQ-010 oMemAddr/oMemData/oMemWe/oMemRe  out  16/8/1/1  external memory port (ROM, VRAM, WRAM, OAM).
REQ-011 iMemData  in  8  external memory read data, combinational from oMemAddr.
REQ-012 oIoAddr/oIoData/oIoWe/oIoRe  out  7/8/1/1  peripheral port for FF00-FF7F; oIoAddr = iCpuAddr[6:0].
REQ-013 iIoData  in  8  peripheral read data, combinational.
REQ-014 oOamAddr/oOamData/oOamWe  out  8/8/1  DMA write port into OAM.
REQ-015 oDmaActive  out  1  high while DMA owns the external port.

Function
REQ-016 Decode: 0000-FEFF external port; FF00-FF7F IO port except FF46; FF46 DMA register; FF80-FFFE HRAM; FFFF IE register (internal).
REQ-017 Read: iCpuReadRequest=1, iCpuWe=0 at edge N -> selected source data registered into oCpuData, valid from cycle N+1, held until next read.
REQ-018 Write: iCpuWe=1 -> oMemWe/oIoWe asserted combinationally same cycle for decoded region; HRAM/IE/FF46 updated at that edge.
REQ-019 iCpuWe and iCpuReadRequest both high: write performed, read ignored, oCpuData unchanged.
REQ-020 oMemRe/oIoRe SHALL assert only in the cycle of a decoded CPU read (or DMA read).
REQ-021 Write to FF46 with value V: latch V, DMA FSM IDLE -> START (1 cycle) -> RD/WR pairs; source high byte = V if V<=8'hDF else V-8'h20.
REQ-022 RD cycle: oMemAddr={src,idx}, oMemRe=1; WR cycle: oOamAddr=idx, oOamData=captured iMemData, oOamWe=1; idx increments after WR.
REQ-023 After WR of idx=P_DMA_LEN-1 FSM returns IDLE; total busy = 1+2*P_DMA_LEN cycles; oDmaActive high in START/RD/WR only.
REQ-024 During DMA: CPU reads of 0000-FF7F return 8'hFF, writes there dropped (no oMemWe/oIoWe); HRAM/IE/FF46 accesses served normally.
REQ-025 Write to FF46 during DMA restarts: new source, idx=0, state START.
REQ-026 Read FF46 returns last written V.

Reset
REQ-027 iReset: oCpuData=8'h00, IE=8'h00, FF46 latch=8'h00, DMA FSM IDLE, idx=0, all strobes 0; HRAM contents not reset.
REQ-028 Reset mid-DMA aborts next cycle; no oOamWe after reset edge.
REQ-029 iReset has priority over every simultaneous CPU access.

Configuration
REQ-030 Macro MCU_RESPONDER_OAM_DMA_EN defined: REQ-021..REQ-026 apply.
REQ-031 Macro undefined: FF46 forwarded to IO port like other IO; oDmaActive, oOamWe, oOamAddr, oOamData tied 0; no DMA FSM.

Structure
REQ-032 Shared definitions include SHALL hold memory-map bounds (region bases/limits, FF46, FFFF) and DMA state encodings.
REQ-033 DMA FSM+counter SHALL be sub-module mcu_oam_dma; top holds decode, HRAM, IE, read mux and bus arbitration.

Verification
REQ-034 Write 8'h5A to FF80, read FF80 -> oCpuData=8'h5A one cycle after read strobe.
REQ-035 Read 0x1234 with iMemData=8'h3C -> oMemRe=1, oMemAddr=16'h1234 that cycle; oCpuData=8'h3C next cycle.
REQ-036 Write 8'hC1 to FF46 -> oDmaActive for 321 cycles; oOamWe pulses 160 times, addr 00..9F, reading C100..C19F; read 0xC000 during DMA -> 8'hFF.
REQ-037 Write 8'hFE to FF46 -> source addresses DE00..DE9F.
REQ-038 Assert iReset at DMA idx=50 -> oDmaActive=0 and no oOamWe next cycle; IE and FF46 read 8'h00.
REQ-039 Simultaneous iCpuWe and iCpuReadRequest to FFFF with data 8'h1F -> IE=8'h1F, oCpuData unchanged.

Source files
------------

// File: rtl/mcu_responder_pkg.sv
// mcu_responder_pkg: shared definitions for the MCU bus responder.
//   - Memory-map bounds used by the address decoder.
//   - OAM DMA state encoding and source-page folding helper.
package mcu_responder_pkg;

  // Memory map
  localparam logic [15:0] EXT_LIMIT    = 16'hFEFF;  // 0000-FEFF external port
  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [15:0] IO_LIMIT     = 16'hFF7F;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] HRAM_LIMIT   = 16'hFFFE;
  localparam logic [15:0] IE_ADDR      = 16'hFFFF;

  // Source pages above DFxx alias down into work RAM.
  localparam logic [7:0] DMA_SRC_FOLD_MAX    = 8'hDF;
  localparam logic [7:0] DMA_SRC_FOLD_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    DmaIdle,
    DmaStart,
    DmaRd,
    DmaWr
  } dma_state_e;

  function automatic logic [7:0] dma_src_hi(input logic [7:0] v);
    return (v <= DMA_SRC_FOLD_MAX) ? v : v - DMA_SRC_FOLD_OFFSET;
  endfunction

endpackage

// File: rtl/mcu_oam_dma.sv
// mcu_oam_dma: OAM DMA sequencer. Copies P_DMA_LEN bytes from page i_src_hi
// of the external port into OAM as alternating read/write cycles.
// Ports:
//   iClock, iReset    clock, synchronous active-high reset
//   i_start           restart transfer (CPU write to FF46)
//   i_src_hi          source high byte, already folded
//   i_mem_data        external read data for the current read cycle
//   o_active          high in START/RD/WR
//   o_mem_addr/_re    external read address / strobe
//   o_oam_addr/_data/_we  OAM write port
module mcu_oam_dma
  import mcu_responder_pkg::*;
#(
  parameter logic [7:0] P_DMA_LEN = 8'hA0
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        i_start,
  input  logic [7:0]  i_src_hi,
  input  logic [7:0]  i_mem_data,
  output logic        o_active,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_re,
  output logic [7:0]  o_oam_addr,
  output logic [7:0]  o_oam_data,
  output logic        o_oam_we
);

  dma_state_e r_state, w_state_next;
  logic [7:0] r_idx;
  logic [7:0] r_src;
  logic [7:0] r_data;
  logic       w_last;

  assign w_last = (r_idx == P_DMA_LEN - 8'd1);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= DmaIdle;
      r_idx   <= 8'h00;
      r_src   <= 8'h00;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (i_start) begin
        r_src <= i_src_hi;
        r_idx <= 8'h00;
      end else if (r_state == DmaWr) begin
        r_idx <= w_last ? 8'h00 : r_idx + 8'd1;
      end
      if (r_state == DmaRd) begin
        r_data <= i_mem_data;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_start) begin
      w_state_next = DmaStart;
    end else begin
      unique case (r_state)
        DmaIdle:  w_state_next = DmaIdle;
        DmaStart: w_state_next = DmaRd;
        DmaRd:    w_state_next = DmaWr;
        DmaWr:    w_state_next = w_last ? DmaIdle : DmaRd;
        default:  w_state_next = DmaIdle;
      endcase
    end
  end

  assign o_active   = (r_state != DmaIdle);
  assign o_mem_addr = {r_src, r_idx};
  assign o_mem_re   = (r_state == DmaRd);
  assign o_oam_addr = r_idx;
  assign o_oam_data = r_data;
  assign o_oam_we   = (r_state == DmaWr);

endmodule

// File: rtl/mcu_responder.sv
// mcu_responder: CPU bus responder. Decodes the CPU address into the external
// memory port (0000-FEFF), peripheral port (FF00-FF7F), internal HRAM
// (FF80-FFFE) and IE register (FFFF); registers read data; arbitrates the
// external port with the OAM DMA engine.
// Build option: define MCU_RESPONDER_OAM_DMA_EN to enable the FF46 OAM DMA.
// Without it FF46 is an ordinary IO address and the DMA outputs are tied 0.
// Ports:
//   iClock, iReset                      clock, synchronous active-high reset
//   iCpuAddr/iCpuData/iCpuReadRequest/iCpuWe   CPU bus request
//   oCpuData                            registered read data
//   oMemAddr/oMemData/oMemWe/oMemRe, iMemData  external memory port
//   oIoAddr/oIoData/oIoWe/oIoRe, iIoData       peripheral port
//   oOamAddr/oOamData/oOamWe            DMA write port into OAM
//   oDmaActive                          DMA owns the external port
module mcu_responder
  import mcu_responder_pkg::*;
#(
  parameter logic [7:0]  P_DMA_LEN    = 8'hA0,
  parameter int unsigned P_HRAM_DEPTH = 127
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuReadRequest,
  input  logic        iCpuWe,
  output logic [7:0]  oCpuData,
  output logic [15:0] oMemAddr,
  output logic [7:0]  oMemData,
  output logic        oMemWe,
  output logic        oMemRe,
  input  logic [7:0]  iMemData,
  output logic [6:0]  oIoAddr,
  output logic [7:0]  oIoData,
  output logic        oIoWe,
  output logic        oIoRe,
  input  logic [7:0]  iIoData,
  output logic [7:0]  oOamAddr,
  output logic [7:0]  oOamData,
  output logic        oOamWe,
  output logic        oDmaActive
);

  logic [7:0] r_hram [P_HRAM_DEPTH];
  logic [7:0] r_ie;
  logic [7:0] r_cpu_data;
  logic [6:0] w_hram_idx;
  logic       w_wr, w_rd;
  logic       w_sel_ext, w_sel_io, w_sel_hram, w_sel_ie;
  logic       w_dma_active;
  logic [7:0] w_rd_data;

  // Reset outranks any CPU access; a write masks a simultaneous read.
  assign w_wr = iCpuWe & ~iReset;
  assign w_rd = iCpuReadRequest & ~iCpuWe & ~iReset;

  assign w_hram_idx = iCpuAddr[6:0];
  assign w_sel_ext  = (iCpuAddr <= EXT_LIMIT);
  assign w_sel_hram = (iCpuAddr >= HRAM_BASE) && (iCpuAddr <= HRAM_LIMIT) &&
                      (32'(w_hram_idx) < P_HRAM_DEPTH);
  assign w_sel_ie   = (iCpuAddr == IE_ADDR);

`ifdef MCU_RESPONDER_OAM_DMA_EN
  logic [7:0]  r_dma_reg;
  logic        w_sel_dma_reg;
  logic [15:0] w_dma_mem_addr;
  logic        w_dma_mem_re;

  assign w_sel_dma_reg = (iCpuAddr == DMA_REG_ADDR);
  assign w_sel_io      = (iCpuAddr >= IO_BASE) && (iCpuAddr <= IO_LIMIT) && !w_sel_dma_reg;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_dma_reg <= 8'h00;
    end else if (w_wr && w_sel_dma_reg) begin
      r_dma_reg <= iCpuData;
    end
  end

  mcu_oam_dma #(
    .P_DMA_LEN (P_DMA_LEN)
  ) u_dma (
    .iClock     (iClock),
    .iReset     (iReset),
    .i_start    (w_wr && w_sel_dma_reg),
    .i_src_hi   (dma_src_hi(iCpuData)),
    .i_mem_data (iMemData),
    .o_active   (w_dma_active),
    .o_mem_addr (w_dma_mem_addr),
    .o_mem_re   (w_dma_mem_re),
    .o_oam_addr (oOamAddr),
    .o_oam_data (oOamData),
    .o_oam_we   (oOamWe)
  );
`else
  logic w_unused_dma_len;

  assign w_sel_io         = (iCpuAddr >= IO_BASE) && (iCpuAddr <= IO_LIMIT);
  assign w_dma_active     = 1'b0;
  assign w_unused_dma_len = ^P_DMA_LEN;
  assign oOamAddr         = 8'h00;
  assign oOamData         = 8'h00;
  assign oOamWe           = 1'b0;
`endif

  assign oDmaActive = w_dma_active;

  // External port: the DMA engine takes it over completely while active.
  always_comb begin
    oMemAddr = iCpuAddr;
    oMemData = iCpuData;
    oMemWe   = w_wr & w_sel_ext & ~w_dma_active;
    oMemRe   = w_rd & w_sel_ext & ~w_dma_active;
`ifdef MCU_RESPONDER_OAM_DMA_EN
    if (w_dma_active) begin
      oMemAddr = w_dma_mem_addr;
      oMemData = 8'h00;
      oMemRe   = w_dma_mem_re;
    end
`endif
  end

  assign oIoAddr = iCpuAddr[6:0];
  assign oIoData = iCpuData;
  assign oIoWe   = w_wr & w_sel_io & ~w_dma_active;
  assign oIoRe   = w_rd & w_sel_io & ~w_dma_active;

  // Read mux; bus regions blocked by DMA and unmapped HRAM read as FF.
  always_comb begin
    w_rd_data = 8'hFF;
    if (w_sel_ext) begin
      w_rd_data = w_dma_active ? 8'hFF : iMemData;
    end else if (w_sel_io) begin
      w_rd_data = w_dma_active ? 8'hFF : iIoData;
`ifdef MCU_RESPONDER_OAM_DMA_EN
    end else if (w_sel_dma_reg) begin
      w_rd_data = r_dma_reg;
`endif
    end else if (w_sel_hram) begin
      w_rd_data = r_hram[w_hram_idx];
    end else if (w_sel_ie) begin
      w_rd_data = r_ie;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_cpu_data <= 8'h00;
      r_ie       <= 8'h00;
    end else begin
      if (w_rd) begin
        r_cpu_data <= w_rd_data;
      end
      if (w_wr && w_sel_ie) begin
        r_ie <= iCpuData;
      end
    end
  end

  // HRAM contents survive reset.
  always_ff @(posedge iClock) begin
    if (w_wr && w_sel_hram) begin
      r_hram[w_hram_idx] <= iCpuData;
    end
  end

  assign oCpuData = r_cpu_data;

endmodule

// File: tb/tb_mcu_responder.sv
// tb_mcu_responder: directed self-checking bench for mcu_responder.
// Exercises the DMA engine when MCU_RESPONDER_OAM_DMA_EN is defined, otherwise
// checks that FF46 behaves as plain IO and the DMA outputs stay low.
module tb_mcu_responder;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic        iCpuReadRequest;
  logic        iCpuWe;
  logic [7:0]  oCpuData;
  logic [15:0] oMemAddr;
  logic [7:0]  oMemData;
  logic        oMemWe;
  logic        oMemRe;
  logic [7:0]  iMemData;
  logic [6:0]  oIoAddr;
  logic [7:0]  oIoData;
  logic        oIoWe;
  logic        oIoRe;
  logic [7:0]  iIoData;
  logic [7:0]  oOamAddr;
  logic [7:0]  oOamData;
  logic        oOamWe;
  logic        oDmaActive;

  logic        tb_mem_force;
  logic [7:0]  tb_mem_val;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Memory model: unless forced, a byte reads as its low address byte ^ A5.
  assign iMemData = tb_mem_force ? tb_mem_val : (oMemAddr[7:0] ^ 8'hA5);

  always #5 iClock = ~iClock;

  mcu_responder dut (
    .iClock          (iClock),
    .iReset          (iReset),
    .iCpuAddr        (iCpuAddr),
    .iCpuData        (iCpuData),
    .iCpuReadRequest (iCpuReadRequest),
    .iCpuWe          (iCpuWe),
    .oCpuData        (oCpuData),
    .oMemAddr        (oMemAddr),
    .oMemData        (oMemData),
    .oMemWe          (oMemWe),
    .oMemRe          (oMemRe),
    .iMemData        (iMemData),
    .oIoAddr         (oIoAddr),
    .oIoData         (oIoData),
    .oIoWe           (oIoWe),
    .oIoRe           (oIoRe),
    .iIoData         (iIoData),
    .oOamAddr        (oOamAddr),
    .oOamData        (oOamData),
    .oOamWe          (oOamWe),
    .oDmaActive      (oDmaActive)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    iCpuAddr = a;
    iCpuData = d;
    iCpuWe   = 1'b1;
    @(negedge iClock);
    iCpuWe   = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    iCpuAddr        = a;
    iCpuReadRequest = 1'b1;
    iCpuWe          = 1'b0;
    @(negedge iClock);
    iCpuReadRequest = 1'b0;
  endtask

`ifdef MCU_RESPONDER_OAM_DMA_EN
  // Follows one transfer from the START cycle until oDmaActive drops.
  task automatic run_dma(input logic [7:0] src, input logic [7:0] v, input logic inject,
                         output int active_n, output int we_n);
    int rd_n;
    active_n = 0;
    we_n     = 0;
    rd_n     = 0;
    for (int c = 0; c < 400; c++) begin
      if (!oDmaActive) break;
      active_n++;
      if (oMemRe) begin
        check_eq("dma_rd_addr", 32'(oMemAddr), 32'({src, 8'(rd_n)}));
        rd_n++;
      end
      if (oOamWe) begin
        check_eq("oam_addr", 32'(oOamAddr), 32'(8'(we_n)));
        check_eq("oam_data", 32'(oOamData), 32'(8'(we_n) ^ 8'hA5));
        we_n++;
      end
      if (inject) begin
        if (active_n == 10) begin
          iCpuAddr        = 16'hC000;
          iCpuReadRequest = 1'b1;
        end
        if (active_n == 11) begin
          iCpuReadRequest = 1'b0;
          check_eq("dma_ext_rd_ff", 32'(oCpuData), 32'h0000_00FF);
          iCpuAddr = 16'hC000;
          iCpuData = 8'h99;
          iCpuWe   = 1'b1;
          #1;
          check_eq("dma_ext_we_drop", 32'(oMemWe), 32'h0);
        end
        if (active_n == 12) begin
          iCpuWe          = 1'b0;
          iCpuAddr        = 16'hFF46;
          iCpuReadRequest = 1'b1;
        end
        if (active_n == 13) begin
          iCpuReadRequest = 1'b0;
          check_eq("dma_ff46_rd", 32'(oCpuData), 32'(v));
        end
      end
      @(negedge iClock);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int act, wes;
    logic found;
    iReset = 1'b1; iCpuAddr = 16'h0100; iCpuData = 8'h55;
    iCpuReadRequest = 1'b0; iCpuWe = 1'b1;
    tb_mem_force = 1'b0; tb_mem_val = 8'h00; iIoData = 8'h00;
    @(negedge iClock);
    #1;
    check_eq("rst_mem_we_blocked", 32'(oMemWe), 32'h0);
    iCpuAddr = 16'hFFFF;
    @(negedge iClock);
    @(negedge iClock);
    iCpuWe = 1'b0;
    iReset = 1'b0;
    check_eq("rst_cpu_data", 32'(oCpuData), 32'h0);
    check_eq("rst_dma_active", 32'(oDmaActive), 32'h0);
    check_eq("rst_oam_we", 32'(oOamWe), 32'h0);
    cpu_read(16'hFFFF);
    check_eq("rst_ie_write_ignored", 32'(oCpuData), 32'h0);

    // HRAM write then read back
    cpu_write(16'hFF80, 8'h5A);
    cpu_read(16'hFF80);
    check_eq("hram_ff80", 32'(oCpuData), 32'h5A);
    @(negedge iClock);
    check_eq("hram_hold", 32'(oCpuData), 32'h5A);
    cpu_write(16'hFFFE, 8'hE7);
    cpu_read(16'hFFFE);
    check_eq("hram_fffe", 32'(oCpuData), 32'hE7);

    // External read
    tb_mem_force = 1'b1; tb_mem_val = 8'h3C;
    iCpuAddr = 16'h1234; iCpuReadRequest = 1'b1;
    #1;
    check_eq("ext_rd_re", 32'(oMemRe), 32'h1);
    check_eq("ext_rd_addr", 32'(oMemAddr), 32'h1234);
    @(negedge iClock);
    iCpuReadRequest = 1'b0;
    check_eq("ext_rd_data", 32'(oCpuData), 32'h3C);
    tb_mem_force = 1'b0;

    // External write
    iCpuAddr = 16'h8000; iCpuData = 8'h77; iCpuWe = 1'b1;
    #1;
    check_eq("ext_wr_we", 32'(oMemWe), 32'h1);
    check_eq("ext_wr_data", 32'(oMemData), 32'h77);
    check_eq("ext_wr_io_quiet", 32'(oIoWe), 32'h0);
    @(negedge iClock);
    iCpuWe = 1'b0;
    #1;
    check_eq("ext_we_one_cycle", 32'(oMemWe), 32'h0);
    @(negedge iClock);

    // IO read and write
    iIoData = 8'h9B; iCpuAddr = 16'hFF05; iCpuReadRequest = 1'b1;
    #1;
    check_eq("io_rd_re", 32'(oIoRe), 32'h1);
    check_eq("io_rd_addr", 32'(oIoAddr), 32'h05);
    check_eq("io_rd_mem_quiet", 32'(oMemRe), 32'h0);
    @(negedge iClock);
    iCpuReadRequest = 1'b0;
    check_eq("io_rd_data", 32'(oCpuData), 32'h9B);
    iCpuAddr = 16'hFF10; iCpuData = 8'h42; iCpuWe = 1'b1;
    #1;
    check_eq("io_wr_we", 32'(oIoWe), 32'h1);
    check_eq("io_wr_mem_quiet", 32'(oMemWe), 32'h0);
    @(negedge iClock);
    iCpuWe = 1'b0;

    // Simultaneous write and read to IE
    iCpuAddr = 16'hFFFF; iCpuData = 8'h1F; iCpuWe = 1'b1; iCpuReadRequest = 1'b1;
    @(negedge iClock);
    iCpuWe = 1'b0; iCpuReadRequest = 1'b0;
    check_eq("wr_rd_cpu_data_held", 32'(oCpuData), 32'h9B);
    cpu_read(16'hFFFF);
    check_eq("ie_value", 32'(oCpuData), 32'h1F);

`ifdef MCU_RESPONDER_OAM_DMA_EN
    // Full transfer from C100 with CPU traffic in the middle
    cpu_write(16'hFF46, 8'hC1);
    run_dma(8'hC1, 8'hC1, 1'b1, act, wes);
    check_eq("dma_c1_busy", 32'(act), 32'd321);
    check_eq("dma_c1_pulses", 32'(wes), 32'd160);
    cpu_read(16'hFF80);
    check_eq("hram_after_dma", 32'(oCpuData), 32'h5A);

    // Source above DF folds down by 20
    cpu_write(16'hFF46, 8'hFE);
    run_dma(8'hDE, 8'hFE, 1'b0, act, wes);
    check_eq("dma_fe_busy", 32'(act), 32'd321);
    check_eq("dma_fe_pulses", 32'(wes), 32'd160);

    // Restart mid-transfer
    cpu_write(16'hFF46, 8'hC1);
    repeat (7) @(negedge iClock);
    cpu_write(16'hFF46, 8'h80);
    run_dma(8'h80, 8'h80, 1'b0, act, wes);
    check_eq("dma_restart_busy", 32'(act), 32'd321);
    check_eq("dma_restart_pulses", 32'(wes), 32'd160);

    // Reset at idx 50
    cpu_write(16'hFF46, 8'hC1);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (oMemRe && oMemAddr == 16'hC132) begin
        found = 1'b1;
        break;
      end
      @(negedge iClock);
    end
    check_eq("dma_reach_idx50", 32'(found), 32'h1);
    iReset = 1'b1;
    @(negedge iClock);
    check_eq("dma_rst_active", 32'(oDmaActive), 32'h0);
    check_eq("dma_rst_oam_we", 32'(oOamWe), 32'h0);
    iReset = 1'b0;
    @(negedge iClock);
    check_eq("dma_rst_oam_we_later", 32'(oOamWe), 32'h0);
    cpu_read(16'hFF46);
    check_eq("dma_rst_ff46", 32'(oCpuData), 32'h0);
    cpu_read(16'hFFFF);
    check_eq("dma_rst_ie", 32'(oCpuData), 32'h0);
`else
    // FF46 is plain IO in this build
    iCpuAddr = 16'hFF46; iCpuData = 8'hC1; iCpuWe = 1'b1;
    #1;
    check_eq("ff46_io_we", 32'(oIoWe), 32'h1);
    check_eq("ff46_io_addr", 32'(oIoAddr), 32'h46);
    @(negedge iClock);
    iCpuWe = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_eq("nodma_active", 32'(oDmaActive), 32'h0);
      check_eq("nodma_oam_we", 32'(oOamWe), 32'h0);
      @(negedge iClock);
    end
    iIoData = 8'h3E; iCpuAddr = 16'hFF46; iCpuReadRequest = 1'b1;
    #1;
    check_eq("ff46_io_re", 32'(oIoRe), 32'h1);
    @(negedge iClock);
    iCpuReadRequest = 1'b0;
    check_eq("ff46_io_rd", 32'(oCpuData), 32'h3E);
    cpu_read(16'hC000);
    check_eq("ext_rd_model", 32'(oCpuData), 32'hA5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
